// File: rtl/vmem_acc_pipe.sv
// Vector data store with two combinational read ports and one pipelined
// write/accumulate port (WRITE, ADD, ADD_SAT, MAX).
// Back-to-back hazards on the same word are forwarded.
// A sequential clear engine zeroes the whole array one word per cycle.
module vmem_acc_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] rv_a,
  output logic [DATA_W-1:0] rv_b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b01;
  localparam logic [1:0] OP_ADD_SAT = 2'b10;
  localparam logic [1:0] OP_MAX     = 2'b11;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;

  logic              p_valid;
  logic [IDX_W-1:0]  p_idx;
  logic [1:0]        p_op;
  logic [DATA_W-1:0] p_data;
  logic [DATA_W-1:0] p_old;
  logic [DATA_W-1:0] p_new;
  logic [DATA_W:0]   p_sum;

  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_in_range;
  logic              p_in_range;
  logic              accept;
  logic [DATA_W-1:0] old_sel;

  // The two lowest address bits select a byte inside a word and are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_a[1:0], addr_b[1:0], wr_addr[1:0]};

  assign idx_a  = addr_a[ADDR_W-1:2];
  assign idx_b  = addr_b[ADDR_W-1:2];
  assign wr_idx = wr_addr[ADDR_W-1:2];

  assign wr_in_range = (wr_idx < DEPTH_IDX);
  assign p_in_range  = (p_idx < DEPTH_IDX);

  // Read ports show committed memory only; out-of-range words read as zero
  assign rv_a = (idx_a < DEPTH_IDX) ? mem[idx_a[CNT_W-1:0]] : '0;
  assign rv_b = (idx_b < DEPTH_IDX) ? mem[idx_b[CNT_W-1:0]] : '0;

  // A clear request always takes priority over a write in the same cycle
  assign wr_ready = (state == IDLE) && !clr_start;
  assign accept   = wr_valid && wr_ready;

  // Operand capture forwards the in-flight result when it targets the same word
  assign old_sel = (p_valid && (p_idx == wr_idx)) ? p_new :
                   (wr_in_range ? mem[wr_idx[CNT_W-1:0]] : '0);

  // Second pipeline stage: combine captured old value with the operand
  always_comb begin
    p_sum = {1'b0, p_old} + {1'b0, p_data};
    p_new = p_data;
    case (p_op)
      OP_WRITE:   p_new = p_data;
      OP_ADD:     p_new = p_sum[DATA_W-1:0];
      OP_ADD_SAT: p_new = p_sum[DATA_W] ? '1 : p_sum[DATA_W-1:0];
      OP_MAX:     p_new = (p_data > p_old) ? p_data : p_old;
      default:    p_new = p_data;
    endcase
  end

  // Memory update: pending pipeline write-back and clear-engine zeroing; reset edges write nothing
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (p_valid && p_in_range) begin
        mem[p_idx[CNT_W-1:0]] <= p_new;
      end
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end
    end
  end

  // First pipeline stage: capture an accepted request and its old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_idx  <= wr_idx;
        p_op   <= wr_op;
        p_data <= wr_data;
        p_old  <= old_sel;
      end
    end
  end

  // Clear engine FSM with registered busy and sticky range-error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
          end else if (accept && !wr_in_range) begin
            err <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_acc_pipe.sv
// Self-checking bench for vmem_acc_pipe: directed scenarios plus randomized
// traffic compared against a transaction-level memory model.
module tb_vmem_acc_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic [DATA_W-1:0] rv_a;
  logic [DATA_W-1:0] rv_b;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [1:0]        wr_op = 2'b00;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_start = 1'b0;
  logic              busy;
  logic              err;

  vmem_acc_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .addr_b(addr_b), .rv_a(rv_a), .rv_b(rv_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard state: committed memory, one outstanding write, clear progress
  logic [31:0] m_mem [DEPTH];
  bit          p_v;
  logic [1:0]  p_op;
  logic [31:0] p_addr;
  logic [31:0] p_data;
  int          clr_left;
  bit          m_err;
  bit          chk_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] op_result(input logic [31:0] old, input logic [1:0] op,
                                            input logic [31:0] d);
    longint s;
    s = longint'(old) + longint'(d);
    case (op)
      2'd0:    return d;
      2'd1:    return old + d;
      2'd2:    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
      default: return (d > old) ? d : old;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    if (i < DEPTH) return m_mem[i];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, DEPTH + 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // One clock cycle: drive at negedge, check before the edge, advance the model at the edge
  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [31:0] wa,
                               input logic [31:0] wd, input bit clr, input bit rstn,
                               input logic [31:0] pa);
    bit          exp_ready;
    bit          idle;
    logic [31:0] pb;
    logic [31:0] wi;
    @(negedge clk);
    rst_n     = rstn;
    wr_valid  = v;
    wr_op     = op;
    wr_addr   = wa;
    wr_data   = wd;
    clr_start = clr;
    addr_a    = pa;
    pb        = rand_addr();
    addr_b    = pb;
    #1;
    idle      = (clr_left == 0);
    exp_ready = idle && !clr;
    checkOutput("wr_ready", 32'(wr_ready), 32'(exp_ready));
    checkOutput("busy", 32'(busy), 32'(!idle));
    checkOutput("err", 32'(err), 32'(m_err));
    if (chk_rd) begin
      checkOutput("rv_a", rv_a, model_read(pa));
      checkOutput("rv_b", rv_b, model_read(pb));
    end
    @(posedge clk);
    if (!rstn) begin
      p_v      = 1'b0;
      clr_left = 0;
      m_err    = 1'b0;
    end else begin
      if (p_v && ((p_addr >> 2) < DEPTH))
        m_mem[p_addr >> 2] = op_result(m_mem[p_addr >> 2], p_op, p_data);
      if (clr_left > 0) begin
        m_mem[DEPTH - clr_left] = 32'h0;
        clr_left--;
      end
      p_v    = v && exp_ready;
      p_op   = op;
      p_addr = wa;
      p_data = wd;
      wi     = wa >> 2;
      if (p_v && (wi >= DEPTH)) m_err = 1'b1;
      if (clr && idle) begin
        clr_left = DEPTH;
        m_err    = 1'b0;
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, rand_addr());
  endtask

  task automatic writeOp(input logic [1:0] op, input logic [31:0] wa, input logic [31:0] wd);
    applyStimulus(1'b1, op, wa, wd, 1'b0, 1'b1, wa);
  endtask

  // Idle cycle holding addr_a, then compare rv_a with a literal after the edge
  task automatic peekWord(input string tag, input logic [31:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, a);
    #2;
    checkOutput(tag, rv_a, exp);
  endtask

  initial begin
    int busy_cnt;
    bit v, clr, rstn;
    logic [31:0] wa, wd, pa;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    p_v = 1'b0; clr_left = 0; m_err = 1'b0; chk_rd = 1'b0;

    // Reset and check reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_ready", 32'(wr_ready), 32'h1);

    // Start from a known all-zero array
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    repeat (DEPTH + 1) idleCycle();
    chk_rd = 1'b1;

    // WRITE then ADD to the same word
    writeOp(2'd0, 32'h8, 32'h10);
    writeOp(2'd1, 32'h8, 32'h5);
    peekWord("write_add", 32'h8, 32'h15);

    // Four back-to-back ADD 1 to word 0
    writeOp(2'd0, 32'h0, 32'h0);
    repeat (4) writeOp(2'd1, 32'h0, 32'h1);
    peekWord("fwd_add4", 32'h0, 32'h4);

    // Saturation, wrap and max
    writeOp(2'd0, 32'h10, 32'hFFFF_FFF0);
    writeOp(2'd2, 32'h10, 32'h20);
    peekWord("add_sat", 32'h10, 32'hFFFF_FFFF);
    writeOp(2'd0, 32'h14, 32'hFFFF_FFF0);
    writeOp(2'd1, 32'h14, 32'h20);
    peekWord("add_wrap", 32'h14, 32'h10);
    writeOp(2'd3, 32'h14, 32'h7);
    peekWord("max_keep", 32'h14, 32'h10);
    writeOp(2'd3, 32'h14, 32'h30);
    peekWord("max_take", 32'h14, 32'h30);

    // Out-of-range write: sticky err, cleared by clr_start
    writeOp(2'd0, 32'(DEPTH * 4), 32'hDEAD_BEEF);
    #2;
    checkOutput("err_set", 32'(err), 32'h1);
    peekWord("oor_read", 32'(DEPTH * 4), 32'h0);
    peekWord("oor_keep", 32'h8, 32'h15);
    checkOutput("err_sticky", 32'(err), 32'h1);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    #2;
    checkOutput("err_clear", 32'(err), 32'h0);
    repeat (DEPTH + 1) idleCycle();

    // Randomized traffic with hazards, occasional clears and resets
    pa = 32'h0;
    for (int n = 0; n < 500; n++) begin
      int r;
      r    = int'($urandom_range(0, 199));
      rstn = (r != 0);
      clr  = (r >= 1 && r <= 3);
      v    = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) wa = rand_addr();
      else wa = (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) wd = $urandom;
      else wd = 32'($urandom_range(0, 15));
      applyStimulus(v, 2'($urandom_range(0, 3)), wa, wd, clr, rstn, pa);
      pa = ($urandom_range(0, 1) == 0) ? wa : rand_addr();
    end
    repeat (DEPTH + 2) idleCycle();

    // Clear colliding with a write request; busy for exactly DEPTH cycles
    writeOp(2'd0, 32'h4, 32'h1234);
    applyStimulus(1'b1, 2'd0, 32'h8, 32'h5555, 1'b1, 1'b1, 32'h4);
    busy_cnt = 0;
    #2;
    if (busy) busy_cnt++;
    for (int k = 0; k < DEPTH + 2; k++) begin
      idleCycle();
      #2;
      if (busy) busy_cnt++;
    end
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) peekWord("cleared", 32'(k * 4), 32'h0);

    // Reset in the middle of a clear at counter 5
    for (int k = 0; k < 5; k++) writeOp(2'd0, 32'(k * 4), 32'(k + 1));
    writeOp(2'd0, 32'h18, 32'hA5A5);
    idleCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    repeat (5) idleCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 5; k++) peekWord("rst_mid_zero", 32'(k * 4), 32'h0);
    peekWord("rst_mid_keep", 32'h18, 32'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
